// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to sign/exponent/significand converter, one normalising shift per clock.
// Optional macro FPCVT_PIPE_ACCEPT_EN: accept the next sample on the edge that consumes the result.
module fpcvt_seq #(
   parameter int DW = 12,
   parameter int EW = 3,
   parameter int FW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_s,
   output logic [EW-1:0] out_e,
   output logic [FW-1:0] out_f,
   output logic          busy
);

   localparam int CW = EW + 1;
   localparam logic [CW-1:0] LZMAX = CW'(2 ** EW);
   localparam logic [EW-1:0] EMAX = {EW{1'b1}};
   localparam logic [DW-1:0] MAG_SAT = {1'b1, {(DW-1){1'b0}}};
   localparam logic [FW-1:0] F_CARRY = {1'b1, {(FW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t        state_reg, state_next;
   logic [DW-1:0] mag_reg, mag_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          sign_reg, sign_next;
   logic          sat_reg, sat_next;
   logic          out_s_reg, out_s_next;
   logic [EW-1:0] out_e_reg, out_e_next;
   logic [FW-1:0] out_f_reg, out_f_next;

   logic          accept;
   logic [DW-1:0] in_mag;
   logic [FW-1:0] f0;
   logic          rbit;
   logic [EW-1:0] e0;
   logic [EW-1:0] rnd_e;
   logic [FW-1:0] rnd_f;

`ifdef FPCVT_PIPE_ACCEPT_EN
   assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
`else
   assign in_ready = (state_reg == IDLE);
`endif

   assign accept    = in_valid && in_ready;
   // Negating the most-negative sample wraps back to 2^(DW-1), which flags saturation.
   assign in_mag    = in_data[DW-1] ? ((~in_data) + {{(DW-1){1'b0}}, 1'b1}) : in_data;
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign out_s     = out_s_reg;
   assign out_e     = out_e_reg;
   assign out_f     = out_f_reg;

   assign f0   = mag_reg[DW-1 -: FW];
   assign rbit = mag_reg[DW-1-FW];
   assign e0   = (cnt_reg == '0) ? EMAX : EW'(LZMAX - cnt_reg);

   always_comb begin
      rnd_e = e0;
      rnd_f = f0;
      if (sat_reg) begin
         rnd_e = EMAX;
         rnd_f = '1;
      end else if (rbit) begin
         if (f0 != '1) begin
            rnd_f = f0 + 1'b1;
         end else if (e0 != EMAX) begin
            rnd_f = F_CARRY;
            rnd_e = e0 + 1'b1;
         end else begin
            rnd_f = '1;
            rnd_e = EMAX;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      mag_next   = mag_reg;
      cnt_next   = cnt_reg;
      sign_next  = sign_reg;
      sat_next   = sat_reg;
      out_s_next = out_s_reg;
      out_e_next = out_e_reg;
      out_f_next = out_f_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               sign_next  = in_data[DW-1];
               mag_next   = in_mag;
               cnt_next   = '0;
               sat_next   = (in_mag == MAG_SAT);
               state_next = NORM;
            end
         end
         NORM: begin
            if (mag_reg[DW-1] || (cnt_reg == LZMAX)) begin
               state_next = ROUND;
            end else begin
               mag_next = mag_reg << 1;
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ROUND: begin
            out_s_next = sign_reg;
            out_e_next = rnd_e;
            out_f_next = rnd_f;
            state_next = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
`ifdef FPCVT_PIPE_ACCEPT_EN
            if (accept) begin
               sign_next  = in_data[DW-1];
               mag_next   = in_mag;
               cnt_next   = '0;
               sat_next   = (in_mag == MAG_SAT);
               state_next = NORM;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         mag_reg   <= '0;
         cnt_reg   <= '0;
         sign_reg  <= 1'b0;
         sat_reg   <= 1'b0;
         out_s_reg <= 1'b0;
         out_e_reg <= '0;
         out_f_reg <= '0;
      end else begin
         state_reg <= state_next;
         mag_reg   <= mag_next;
         cnt_reg   <= cnt_next;
         sign_reg  <= sign_next;
         sat_reg   <= sat_next;
         out_s_reg <= out_s_next;
         out_e_reg <= out_e_next;
         out_f_reg <= out_f_next;
      end
   end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Self-checking bench for fpcvt_seq: arithmetic reference model plus directed vectors with hand-computed results.
module tb_fpcvt_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_s;
   logic [2:0]  out_e;
   logic [3:0]  out_f;
   logic        busy;

   fpcvt_seq #(.DW(12), .EW(3), .FW(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_e(out_e), .out_f(out_f), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       s;
      logic [2:0] e;
      logic [3:0] f;
      int         acc;
      int         due;
      bit         seen;
   } exp_t;

   exp_t q[$];
   int   edge_idx = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   post_rst = 1'b0;
   int   last_lat = -1;
   int   hs_edge = -1;
   int   acc_edge = -1;
   logic       last_s;
   logic [2:0] last_e;
   logic [3:0] last_f;

   always @(posedge clk) edge_idx <= edge_idx + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_idx);
      end
   endfunction

   // Reference: magnitude, leading-zero count capped at 8, then round-half-up with carry/saturation.
   function automatic void model(input logic [11:0] d, output logic s, output logic [2:0] e,
                                 output logic [3:0] f, output int lz);
      int m, sh, f0, r, e0, sum;
      s  = d[11];
      m  = s ? (4096 - int'(d)) : int'(d);
      lz = 0;
      while (lz < 8 && ((m << lz) < 2048)) lz++;
      sh = (m << lz) & 4095;
      f0 = sh >> 8;
      r  = (sh >> 7) & 1;
      e0 = (lz == 0) ? 7 : 8 - lz;
      sum = f0 + r;
      if (m == 2048) begin
         e = 3'd7; f = 4'hF;
      end else if (sum == 16) begin
         if (e0 < 7) begin e = 3'(e0 + 1); f = 4'h8; end
         else begin e = 3'd7; f = 4'hF; end
      end else begin
         e = 3'(e0); f = 4'(sum);
      end
   endfunction

   always @(negedge clk) begin
      bit ev, er;
      ev = (q.size() != 0) && (q[0].due <= edge_idx);
`ifdef FPCVT_PIPE_ACCEPT_EN
      er = (q.size() == 0) || (q.size() == 1 && ev && out_ready);
`else
      er = (q.size() == 0);
`endif
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(er));
      if (ev && out_valid) begin
         chk("out_s", 32'(out_s), 32'(q[0].s));
         chk("out_e", 32'(out_e), 32'(q[0].e));
         chk("out_f", 32'(out_f), 32'(q[0].f));
         if (!q[0].seen) begin
            q[0].seen = 1'b1;
            last_lat = edge_idx - q[0].acc;
         end
      end
      if (post_rst) begin
         chk("rst_s", 32'(out_s), 32'd0);
         chk("rst_e", 32'(out_e), 32'd0);
         chk("rst_f", 32'(out_f), 32'd0);
      end
      if (rst) begin
         q.delete();
         post_rst = 1'b1;
      end else begin
         if (out_valid && out_ready && q.size() != 0) begin
            hs_edge = edge_idx + 1;
            last_s = out_s; last_e = out_e; last_f = out_f;
            $display("[TB] result s=%0d e=%0d f=%b latency=%0d", out_s, out_e, out_f, last_lat);
            void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
            exp_t x;
            int lz;
            model(in_data, x.s, x.e, x.f, lz);
            x.acc = edge_idx + 1;
            x.due = edge_idx + 1 + lz + 2;
            x.seen = 1'b0;
            q.push_back(x);
            acc_edge = edge_idx + 1;
            post_rst = 1'b0;
         end
      end
   end

   task automatic send(input logic [11:0] d);
      int n;
      bit ok;
      n = 0; ok = 1'b0;
      in_data = d; in_valid = 1'b1;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!ok) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL send_timeout: sample %h not accepted within %0d cycles", d, n);
      end
      in_valid = 1'b0;
      in_data = 12'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL done_timeout: %0d results outstanding after %0d cycles", q.size(), n);
         q.delete();
      end
   endtask

   task automatic run_vec(input logic [11:0] d, input logic s, input logic [2:0] e,
                          input logic [3:0] f, input int lat);
      logic ms; logic [2:0] me; logic [3:0] mf; int lz;
      model(d, ms, me, mf, lz);
      chk("model_e", 32'(me), 32'(e));
      chk("model_f", 32'(mf), 32'(f));
      send(d);
      wait_done();
      chk("lit_s", 32'(last_s), 32'(s));
      chk("lit_e", 32'(last_e), 32'(e));
      chk("lit_f", 32'(last_f), 32'(f));
      chk("lit_latency", 32'(last_lat), 32'(lat));
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      run_vec(12'h000, 1'b0, 3'd0, 4'b0000, 10);
      run_vec(12'h1A6, 1'b0, 3'd5, 4'b1101, 5);
      run_vec(12'hE5A, 1'b1, 3'd5, 4'b1101, 5);
      run_vec(12'h07D, 1'b0, 3'd4, 4'b1000, 7);
      run_vec(12'h7FF, 1'b0, 3'd7, 4'b1111, 3);
      run_vec(12'h800, 1'b1, 3'd7, 4'b1111, 2);
      run_vec(12'h001, 1'b0, 3'd0, 4'b0001, 10);
      run_vec(12'hFFF, 1'b1, 3'd0, 4'b0001, 10);

      // Backpressure: result held for six cycles before release
      out_ready = 1'b0;
      send(12'h1A6);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_valid_seen", 32'(out_valid), 32'd1);
      repeat (6) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done();
      chk("bp_e", 32'(last_e), 32'd5);
      chk("bp_f", 32'(last_f), 32'hD);
      chk("bp_idle_after", 32'(busy), 32'd0);

      // Reset while normalising 0x001
      send(12'h001);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_e", 32'(out_e), 32'd0);
      chk("mid_rst_f", 32'(out_f), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("mid_rst_no_result", 32'(out_valid), 32'd0);
      run_vec(12'h400, 1'b0, 3'd7, 4'b1000, 3);

      // Back-to-back with out_ready held high
      send(12'h400);
      send(12'h200);
`ifdef FPCVT_PIPE_ACCEPT_EN
      chk("b2b_gap", 32'(acc_edge - hs_edge), 32'd0);
`else
      chk("b2b_gap", 32'(acc_edge - hs_edge), 32'd1);
`endif
      wait_done();
      chk("b2b_e", 32'(last_e), 32'd6);
      chk("b2b_f", 32'(last_f), 32'h8);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
